// File: rtl/rx_frame_fifo_pkg.sv
// rtl/rx_frame_fifo_pkg.sv - shared serial frame layout constants
// Used by both the receive FIFO and the transmit side.
package rx_frame_fifo_pkg;
  localparam int FRAME_W       = 10;
  localparam int START_BIT     = 0;
  localparam int STOP_BIT      = 9;
  localparam int DATA_LSB      = 1;
  localparam int DATA_MSB      = 8;
  localparam int DEFAULT_DEPTH = 8;
endpackage

// File: rtl/rx_frame_fifo_if.sv
// rtl/rx_frame_fifo_if.sv - receiver/processor side signals of the rx frame FIFO
interface rx_frame_fifo_if
  import rx_frame_fifo_pkg::*;
#(
  parameter int WIDTH  = FRAME_W,
  parameter int ADDR_W = $clog2(DEFAULT_DEPTH)
);
  logic [WIDTH-1:0] frame_in;
  logic             frame_valid;
  logic [WIDTH-1:0] data_out;
  logic             data_err;
  logic             data_ready;
  logic             data_ack;
  logic [ADDR_W:0]  count;
  logic             overflow;
  logic             clear_overflow;

  modport master (
    output frame_in, frame_valid, data_ack, clear_overflow,
    input  data_out, data_err, data_ready, count, overflow
  );

  modport slave (
    input  frame_in, frame_valid, data_ack, clear_overflow,
    output data_out, data_err, data_ready, count, overflow
  );
endinterface

// File: rtl/rx_frame_fifo_edge_detect.sv
// rtl/rx_frame_fifo_edge_detect.sv - rising-edge pulse from a level input
// RESET_VAL=1 keeps a level already high at reset release from looking like an edge.
module rx_frame_fifo_edge_detect #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);
  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) level_q <= RESET_VAL;
    else       level_q <= level_i;
  end

  assign pulse_o = level_i & ~level_q & ~reset;
endmodule

// File: rtl/rx_frame_fifo.sv
// rtl/rx_frame_fifo.sv - show-ahead FIFO of received serial frames with framing check
// Entries are {err, frame}; head is forced to zero when empty.
module rx_frame_fifo
  import rx_frame_fifo_pkg::*;
#(
  parameter int WIDTH  = FRAME_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  rx_frame_fifo_if.slave  bus
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  logic push_req, pop_req;
  logic full, empty, do_push, do_pop, frame_err;

  rx_frame_fifo_edge_detect #(.RESET_VAL(1'b1)) u_fv_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (bus.frame_valid),
    .pulse_o (push_req)
  );

  rx_frame_fifo_edge_detect #(.RESET_VAL(1'b1)) u_ack_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (bus.data_ack),
    .pulse_o (pop_req)
  );

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign frame_err = bus.frame_in[START_BIT] | ~bus.frame_in[WIDTH-1];
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign do_pop    = pop_req & ~empty;
  assign do_push   = push_req & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_req && full && !do_pop) ovf_d = 1'b1;
    else if (bus.clear_overflow)     ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {frame_err, bus.frame_in};
  end

  assign bus.data_out   = empty ? '0   : mem_q[rd_ptr_q][WIDTH-1:0];
  assign bus.data_err   = empty ? 1'b0 : mem_q[rd_ptr_q][WIDTH];
  assign bus.data_ready = ~empty;
  assign bus.count      = count_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_rx_frame_fifo.sv
// tb/tb_rx_frame_fifo.sv - self-checking bench for rx_frame_fifo against a queue model
module tb_rx_frame_fifo;
  import rx_frame_fifo_pkg::*;

  localparam int W = 10;
  localparam int D = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_en = 1'b0;

  rx_frame_fifo_if #(.WIDTH(W), .ADDR_W(3)) bus ();

  rx_frame_fifo #(.WIDTH(W), .DEPTH(D), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [W:0] mq[$];
  bit m_ovf, m_pfv, m_pack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  task automatic model_step();
    bit push, pop, set_ovf;
    int cnt;
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0; m_pfv = 1'b1; m_pack = 1'b1;
    end else begin
      push = bus.frame_valid && !m_pfv;
      pop  = bus.data_ack && !m_pack;
      cnt  = mq.size();
      set_ovf = push && cnt == D && !pop;
      if (pop && cnt > 0) void'(mq.pop_front());
      if (push && (cnt < D || pop))
        mq.push_back({(bus.frame_in[0] != 1'b0) || (bus.frame_in[W-1] != 1'b1), bus.frame_in});
      if (set_ovf) m_ovf = 1'b1;
      else if (bus.clear_overflow) m_ovf = 1'b0;
      m_pfv = bus.frame_valid; m_pack = bus.data_ack;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("data_ready", 32'(bus.data_ready), 32'(mq.size() != 0));
      chk("data_out", 32'(bus.data_out), mq.size() != 0 ? 32'(mq[0][W-1:0]) : 32'd0);
      chk("data_err", 32'(bus.data_err), mq.size() != 0 ? 32'(mq[0][W]) : 32'd0);
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [W-1:0] f);
    bus.frame_in = f; bus.frame_valid = 1'b1; step();
    bus.frame_valid = 1'b0; step();
  endtask

  task automatic pop();
    bus.data_ack = 1'b1; step();
    bus.data_ack = 1'b0; step();
  endtask

  initial begin
    logic [7:0] pl;
    bus.frame_in = '0; bus.frame_valid = 1'b0; bus.data_ack = 1'b0; bus.clear_overflow = 1'b0;
    reset = 1'b1; step();
    cmp_en = 1'b1; step();
    reset = 1'b0; step();
    chk("reset_ready", 32'(bus.data_ready), 0);
    chk("reset_out", 32'(bus.data_out), 0);
    chk("reset_count", 32'(bus.count), 0);

    push(10'b1_01000001_0);
    chk("A_out", 32'(bus.data_out), 32'h282);
    chk("A_err", 32'(bus.data_err), 0);
    chk("A_count", 32'(bus.count), 1);
    pop();
    chk("A_pop_ready", 32'(bus.data_ready), 0);
    chk("A_pop_out", 32'(bus.data_out), 0);

    for (int i = 0; i < 9; i++) begin
      push(mk(8'h30 + 8'(i)));
      if (i == 7) begin
        chk("fill_count", 32'(bus.count), 8);
        chk("fill_ovf", 32'(bus.overflow), 0);
      end
    end
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 8);
    for (int i = 0; i < 8; i++) begin
      pl = bus.data_out[DATA_MSB:DATA_LSB];
      chk("drain_order", 32'(pl), 32'h30 + 32'(i));
      pop();
    end
    chk("ovf_sticky", 32'(bus.overflow), 1);
    bus.clear_overflow = 1'b1; step();
    bus.clear_overflow = 1'b0;
    chk("ovf_clear", 32'(bus.overflow), 0);

    push(10'b0_01100001_0);
    chk("ferr_err", 32'(bus.data_err), 1);
    pl = bus.data_out[DATA_MSB:DATA_LSB];
    chk("ferr_payload", 32'(pl), 32'h61);
    pop();

    for (int i = 0; i < 8; i++) push(mk(8'h40 + 8'(i)));
    bus.frame_in = mk(8'h48); bus.frame_valid = 1'b1; bus.data_ack = 1'b1; step();
    bus.frame_valid = 1'b0; bus.data_ack = 1'b0;
    chk("simfull_count", 32'(bus.count), 8);
    chk("simfull_ovf", 32'(bus.overflow), 0);
    chk("simfull_head", 32'(bus.data_out), 32'(mk(8'h41)));
    step();
    for (int i = 0; i < 7; i++) pop();
    chk("simfull_tail", 32'(bus.data_out), 32'(mk(8'h48)));
    pop();
    bus.frame_in = mk(8'h49); bus.frame_valid = 1'b1; bus.data_ack = 1'b1; step();
    bus.frame_valid = 1'b0; bus.data_ack = 1'b0;
    chk("simempty_count", 32'(bus.count), 1);
    step(); pop();

    bus.frame_in = mk(8'h55); bus.frame_valid = 1'b1;
    repeat (20) step();
    bus.frame_valid = 1'b0; step();
    chk("fv_hold", 32'(bus.count), 1);
    push(mk(8'h56));
    bus.data_ack = 1'b1;
    repeat (10) step();
    bus.data_ack = 1'b0; step();
    chk("ack_hold", 32'(bus.count), 1);
    chk("ack_hold_head", 32'(bus.data_out), 32'(mk(8'h56)));

    bus.frame_valid = 1'b1; reset = 1'b1; step();
    reset = 1'b0; repeat (3) step();
    chk("fv_across_reset", 32'(bus.count), 0);
    bus.frame_valid = 1'b0; step();

    for (int i = 0; i < 5; i++) push(mk(8'h70 + 8'(i)));
    chk("mid_count5", 32'(bus.count), 5);
    reset = 1'b1; bus.frame_in = mk(8'h7F); bus.frame_valid = 1'b1; step();
    reset = 1'b0; bus.frame_valid = 1'b0; step();
    chk("mid_count0", 32'(bus.count), 0);
    chk("mid_ready", 32'(bus.data_ready), 0);
    chk("mid_ovf", 32'(bus.overflow), 0);
    push(mk(8'h5A));
    chk("mid_push", 32'(bus.data_out), 32'(mk(8'h5A)));
    pop();
    chk("mid_pop", 32'(bus.count), 0);

    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 2000; c++) begin
        bus.frame_valid = 1'($urandom_range(0, 1));
        bus.data_ack = (ph == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
        bus.clear_overflow = ($urandom_range(0, 15) == 0);
        reset = ($urandom_range(0, 299) == 0);
        bus.frame_in = W'($urandom);
        if ($urandom_range(0, 3) != 0) begin
          bus.frame_in[0] = 1'b0; bus.frame_in[W-1] = 1'b1;
        end
        step();
      end
    end
    reset = 1'b0; bus.frame_valid = 1'b0; bus.data_ack = 1'b0; bus.clear_overflow = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
